// File: rtl/ttt_button_conditioner_pkg.sv
// Shared types for the tic-tac-toe button conditioner: debounce FSM states,
// button indices and the fixed-priority pick used by the top-level arbiter.
package ttt_button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    HELD    = 2'b10,
    RELEASE = 2'b11
  } btn_state_t;

  localparam int NUM_BTN = 5;
  localparam int BTN_R   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_U   = 3;
  localparam int BTN_C   = 4;

  // Higher index wins, so C > U > D > L > R falls out of the index order.
  function automatic logic [NUM_BTN-1:0] pick_highest(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] g;
    g = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ttt_btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM, registered press pulse and
// (with BTN_AUTOREPEAT_EN defined) hold-to-repeat pulses.
module ttt_btn_debounce
  import ttt_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 20000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync;
  logic [1:0]  fill;
  logic        s;
  logic        seen_low;
  btn_state_t  state;
  btn_state_t  state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic        press_nxt;
  logic        rpt_fire;

  if (REPEAT_EN && (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  assign s = sync[1];

  // A button held through reset must be seen low (with a filled synchroniser)
  // before it may arm again; the reset-cleared sync flops do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      fill     <= '0;
      seen_low <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      fill     <= {fill[0], 1'b1};
      seen_low <= seen_low | (fill[1] & ~s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (s && seen_low) begin
          state_nxt = ARM;
          cnt_nxt   = CW'(1);
        end
      end
      ARM: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = RELEASE;
          cnt_nxt   = CW'(1);
        end else if (rpt_fire) begin
          press_nxt = 1'b1;
        end
      end
      RELEASE: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign held = (state == HELD) || (state == RELEASE);

`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_repeat
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rlast;
    logic          rphase;

    // First repeat waits REPEAT_DELAY after the accept pulse, later ones REPEAT_PERIOD.
    assign rlast    = rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rpt_fire = (state == HELD) && s && (rcnt == rlast);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (state != HELD || state_nxt != HELD) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rpt_fire) begin
        rcnt   <= '0;
        rphase <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end else begin : g_no_repeat
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/ttt_button_conditioner.sv
// Five debounced buttons -> registered one-hot press pulses (priority C>U>D>L>R)
// gated by enable; optional hold-to-repeat on L/R/U/D via BTN_AUTOREPEAT_EN.
module ttt_button_conditioner
  import ttt_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 20000000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       u_BtnL,
  input  logic       u_BtnR,
  input  logic       u_BtnU,
  input  logic       u_BtnD,
  input  logic       u_BtnC,
  output logic       BtnL,
  output logic       BtnR,
  output logic       BtnU,
  output logic       BtnD,
  output logic       BtnC,
  output logic [4:0] held
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pulse;

  assign raw_btn[BTN_R] = u_BtnR;
  assign raw_btn[BTN_L] = u_BtnL;
  assign raw_btn[BTN_D] = u_BtnD;
  assign raw_btn[BTN_U] = u_BtnU;
  assign raw_btn[BTN_C] = u_BtnC;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
    ttt_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (k != BTN_C)
    ) u_debounce (
      .clk  (Clk),
      .rst_n(reset_n),
      .raw  (raw_btn[k]),
      .press(press[k]),
      .held (held[k])
    );
  end

  // Losing requests are dropped outright; a disabled press is never replayed.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse <= '0;
    end else begin
      pulse <= enable ? pick_highest(press) : '0;
    end
  end

  assign BtnR = pulse[BTN_R];
  assign BtnL = pulse[BTN_L];
  assign BtnD = pulse[BTN_D];
  assign BtnU = pulse[BTN_U];
  assign BtnC = pulse[BTN_C];

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Directed bench for ttt_button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8); repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_ttt_button_conditioner;

  logic       Clk;
  logic       reset_n;
  logic       enable;
  logic       u_BtnL, u_BtnR, u_BtnU, u_BtnD, u_BtnC;
  logic       BtnL, BtnR, BtnU, BtnD, BtnC;
  logic [4:0] held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcnt[5];
  int last_cyc[5];
  int multi    = 0;
  int wide     = 0;
  int rq[$];
  logic [4:0] prev_pulses = '0;

  ttt_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .Clk    (Clk),
    .reset_n(reset_n),
    .enable (enable),
    .u_BtnL (u_BtnL),
    .u_BtnR (u_BtnR),
    .u_BtnU (u_BtnU),
    .u_BtnD (u_BtnD),
    .u_BtnC (u_BtnC),
    .BtnL   (BtnL),
    .BtnR   (BtnR),
    .BtnU   (BtnU),
    .BtnD   (BtnD),
    .BtnC   (BtnC),
    .held   (held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc = cyc + 1;

  // Pulse monitor, order {C,U,D,L,R} to match held.
  always @(negedge Clk) begin
    logic [4:0] p;
    p = {BtnC, BtnU, BtnD, BtnL, BtnR};
    for (int k = 0; k < 5; k++) begin
      if (p[k]) begin
        pcnt[k]     = pcnt[k] + 1;
        last_cyc[k] = cyc;
      end
    end
    if (p[0]) rq.push_back(cyc);
    if ($countones(p) > 1) multi = multi + 1;
    if ((p & prev_pulses) != 5'b0) wide = wide + 1;
    prev_pulses = p;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 5; k++) begin
      pcnt[k]     = 0;
      last_cyc[k] = -1;
    end
    rq.delete();
  endtask

  initial begin
    int c0;
    int exp_r[$];
    reset_n = 1'b0;
    enable  = 1'b1;
    {u_BtnL, u_BtnR, u_BtnU, u_BtnD, u_BtnC} = 5'b0;
    clr();

    // Reset state
    tick(3);
    check("reset_pulses", {BtnC, BtnU, BtnD, BtnL, BtnR}, 5'b0);
    check("reset_held", held, 5'b0);
    reset_n = 1'b1;
    tick(6);

    // 1: clean R press, 10 cycles
    clr();
    c0 = cyc;
    u_BtnR = 1'b1;
    tick(8);
    check("t1_held", held, 5'b00001);
    tick(2);
    u_BtnR = 1'b0;
    tick(12);
    check("t1_count", pcnt[0], 1);
    check("t1_latency", last_cyc[0], c0 + 7);
    check("t1_others", pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4], 0);
    check("t1_held_released", held, 5'b0);

    // 2: bouncing L, then steady high
    clr();
    u_BtnL = 1'b1; tick(1);
    u_BtnL = 1'b0; tick(1);
    u_BtnL = 1'b1; tick(1);
    u_BtnL = 1'b0; tick(1);
    c0 = cyc;
    u_BtnL = 1'b1;
    tick(10);
    u_BtnL = 1'b0;
    tick(20);
    check("t2_count", pcnt[1], 1);
    check("t2_latency", last_cyc[1], c0 + 7);

    // 3: C and U together, C wins
    clr();
    c0 = cyc;
    u_BtnC = 1'b1;
    u_BtnU = 1'b1;
    tick(8);
    check("t3_held", held, 5'b11000);
    tick(2);
    u_BtnC = 1'b0;
    u_BtnU = 1'b0;
    tick(20);
    check("t3_c_count", pcnt[4], 1);
    check("t3_c_latency", last_cyc[4], c0 + 7);
    check("t3_u_count", pcnt[3], 0);

    // 4: reset mid-ARM while D held, then re-press
    clr();
    u_BtnD = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("t4_held_after_reset", held, 5'b0);
    check("t4_no_pulse", pcnt[2], 0);
    u_BtnD = 1'b0;
    tick(6);
    c0 = cyc;
    u_BtnD = 1'b1;
    tick(8);
    check("t4_held_repress", held, 5'b00100);
    // async reset clears held without a clock edge
    reset_n = 1'b0;
    #2;
    check("t4_async_held", held, 5'b0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    u_BtnD = 1'b0;
    tick(20);
    check("t4_repress_count", pcnt[2], 1);
    check("t4_repress_latency", last_cyc[2], c0 + 7);

    // 5: enable low over the U accept cycle
    clr();
    enable = 1'b0;
    u_BtnU = 1'b1;
    tick(9);
    check("t5_held_disabled", held, 5'b01000);
    enable = 1'b1;
    tick(5);
    u_BtnU = 1'b0;
    tick(20);
    check("t5_suppressed", pcnt[3], 0);
    c0 = cyc;
    u_BtnU = 1'b1;
    tick(10);
    u_BtnU = 1'b0;
    tick(20);
    check("t5_enabled_count", pcnt[3], 1);
    check("t5_enabled_latency", last_cyc[3], c0 + 7);

    // 6: 60-cycle holds on R and C
    clr();
    c0 = cyc;
    u_BtnR = 1'b1;
    tick(60);
    u_BtnR = 1'b0;
    tick(20);
`ifdef BTN_AUTOREPEAT_EN
    exp_r = '{c0 + 7, c0 + 27, c0 + 35, c0 + 43, c0 + 51, c0 + 59};
`else
    exp_r = '{c0 + 7};
`endif
    check("t6_r_count", rq.size(), exp_r.size());
    for (int i = 0; i < exp_r.size(); i++) begin
      check($sformatf("t6_r_pulse%0d", i), (i < rq.size()) ? rq[i] : -1, exp_r[i]);
    end
    c0 = cyc;
    u_BtnC = 1'b1;
    tick(60);
    u_BtnC = 1'b0;
    tick(20);
    check("t6_c_count", pcnt[4], 1);
    check("t6_c_latency", last_cyc[4], c0 + 7);

    // Whole-run invariants
    check("one_pulse_per_cycle", multi, 0);
    check("pulse_width_one", wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
